// File: rtl/usb_pkg.sv
// Shared USB transmit definitions: packet request encodings, PID and SYNC bytes,
// CRC16 constants and the framer state type.
package usb_pkg;

  typedef enum logic [1:0] {
    PKT_NONE  = 2'b00,
    PKT_DATA0 = 2'b01,
    PKT_NAK   = 2'b10,
    PKT_ACK   = 2'b11
  } tx_packet_e;

  localparam logic [7:0]  SYNC_BYTE   = 8'h80;
  localparam logic [7:0]  PID_DATA0   = 8'hC3;
  localparam logic [7:0]  PID_ACK     = 8'hD2;
  localparam logic [7:0]  PID_NAK     = 8'h5A;
  localparam logic [15:0] CRC16_POLY  = 16'hA001;  // 0x8005 bit-reflected
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [6:0]  MAX_PAYLOAD = 7'd64;

  typedef enum logic [3:0] {
    IDLE, SYNC, PID, FETCH, LOAD, DATA, CRC_LO, CRC_HI, WAIT_REL
  } tx_state_e;

  function automatic logic [7:0] pid_byte(input tx_packet_e pkt);
    case (pkt)
      PKT_DATA0: pid_byte = PID_DATA0;
      PKT_ACK:   pid_byte = PID_ACK;
      PKT_NAK:   pid_byte = PID_NAK;
      default:   pid_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/tx_packet_framer_if.sv
// Framer boundary: request/payload side from the protocol controller and the
// byte handshake toward the bit encoder. The framer owns the master side.
interface tx_packet_framer_if;
  logic [1:0] TX_Packet;
  logic [6:0] TX_Packet_Data_Size;
  logic [7:0] TX_Packet_Data;
  logic       Get_TX_Packet_Data;
  logic [7:0] tx_byte;
  logic       tx_byte_valid;
  logic       tx_byte_ready;
  logic       tx_byte_last;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    input  TX_Packet, TX_Packet_Data_Size, TX_Packet_Data, tx_byte_ready,
    output Get_TX_Packet_Data, tx_byte, tx_byte_valid, tx_byte_last,
           tx_busy, tx_done, tx_error
  );

  modport slave (
    output TX_Packet, TX_Packet_Data_Size, TX_Packet_Data, tx_byte_ready,
    input  Get_TX_Packet_Data, tx_byte, tx_byte_valid, tx_byte_last,
           tx_busy, tx_done, tx_error
  );
endinterface

// File: rtl/usb_crc16.sv
// Byte-wise CRC16 next-state (reflected 0x8005, LSB first); purely combinational,
// the running remainder register lives in the framer.
module usb_crc16
  import usb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  always_comb begin
    logic [15:0] c;
    c = crc_in ^ {8'h00, byte_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/tx_packet_framer.sv
// USB transmit packet framer: turns a packet request into SYNC, PID, optional
// DATA0 payload and CRC16 bytes on a valid/ready byte stream.
module tx_packet_framer
  import usb_pkg::*;
(
  input logic               clk,
  input logic               rst,
  tx_packet_framer_if.master bus
);

  tx_state_e   state, state_n;
  tx_packet_e  pkt, pkt_n;
  logic [6:0]  size, size_n;
  logic [6:0]  cnt, cnt_n;
  logic [15:0] crc, crc_n, crc_calc;
  logic [7:0]  tx_byte, tx_byte_n;
  logic        armed, armed_n;
  logic        done, done_n;
  logic        error, error_n;
  logic        valid, hs;

  usb_crc16 u_crc (
    .crc_in  (crc),
    .byte_in (bus.TX_Packet_Data),
    .crc_out (crc_calc)
  );

  assign valid = (state == SYNC) || (state == PID) || (state == DATA) ||
                 (state == CRC_LO) || (state == CRC_HI);
  assign hs    = valid && bus.tx_byte_ready;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    pkt_n     = pkt;
    size_n    = size;
    cnt_n     = cnt;
    crc_n     = crc;
    tx_byte_n = tx_byte;
    armed_n   = armed;
    done_n    = 1'b0;
    error_n   = 1'b0;

    if (bus.TX_Packet == PKT_NONE) armed_n = 1'b1;

    case (state)
      IDLE: begin
        if (armed && bus.TX_Packet != PKT_NONE) begin
          armed_n = 1'b0;
          pkt_n   = tx_packet_e'(bus.TX_Packet);
          size_n  = bus.TX_Packet_Data_Size;
          cnt_n   = 7'd0;
          crc_n   = CRC16_INIT;
          if (bus.TX_Packet == PKT_DATA0 && bus.TX_Packet_Data_Size > MAX_PAYLOAD) begin
            error_n = 1'b1;
            state_n = WAIT_REL;
          end else begin
            tx_byte_n = SYNC_BYTE;
            state_n   = SYNC;
          end
        end
      end
      SYNC: if (hs) begin
        tx_byte_n = pid_byte(pkt);
        state_n   = PID;
      end
      PID: if (hs) begin
        if (pkt != PKT_DATA0) begin
          done_n    = 1'b1;
          tx_byte_n = 8'h00;
          state_n   = WAIT_REL;
        end else if (size == 7'd0) begin
          tx_byte_n = ~crc[7:0];
          state_n   = CRC_LO;
        end else begin
          state_n = FETCH;
        end
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        tx_byte_n = bus.TX_Packet_Data;
        crc_n     = crc_calc;
        cnt_n     = cnt + 7'd1;
        state_n   = DATA;
      end
      DATA: if (hs) begin
        if (cnt == size) begin
          tx_byte_n = ~crc[7:0];
          state_n   = CRC_LO;
        end else begin
          state_n = FETCH;
        end
      end
      CRC_LO: if (hs) begin
        tx_byte_n = ~crc[15:8];
        state_n   = CRC_HI;
      end
      CRC_HI: if (hs) begin
        done_n    = 1'b1;
        tx_byte_n = 8'h00;
        state_n   = WAIT_REL;
      end
      WAIT_REL: if (bus.TX_Packet == PKT_NONE) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pkt     <= PKT_NONE;
      size    <= 7'd0;
      cnt     <= 7'd0;
      crc     <= CRC16_INIT;
      tx_byte <= 8'h00;
      armed   <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_n;
      pkt     <= pkt_n;
      size    <= size_n;
      cnt     <= cnt_n;
      crc     <= crc_n;
      tx_byte <= tx_byte_n;
      armed   <= armed_n;
      done    <= done_n;
      error   <= error_n;
    end
  end

  assign bus.tx_byte            = tx_byte;
  assign bus.tx_byte_valid      = valid;
  assign bus.tx_byte_last       = ((state == PID) && (pkt != PKT_DATA0)) || (state == CRC_HI);
  assign bus.Get_TX_Packet_Data = (state == FETCH);
  assign bus.tx_busy            = valid || (state == FETCH) || (state == LOAD);
  assign bus.tx_done            = done;
  assign bus.tx_error           = error;

endmodule
